// File: rtl/enum_pkg.sv
// Shared enumerations for the execute stage.
// br_ty_e: 3-bit branch type consumed by branch_resolve_unit.
package enum_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        NB   = 3'b010,
        J    = 3'b011,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_ty_e;

endpackage

// File: rtl/branch_pht.sv
// Pattern history table of saturating counters, one lookup port, one update port.
// Ports: i_clk, i_rst, i_upd_en/i_upd_idx/i_upd_tk (update), i_lk_idx/o_lk_ctr (lookup).
module branch_pht #(
    parameter int PHT_DEPTH = 64,
    parameter int CTR_BITS  = 2,
    parameter int IDX_W     = $clog2(PHT_DEPTH)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_upd_en,
    input  logic [IDX_W-1:0]    i_upd_idx,
    input  logic                i_upd_tk,
    input  logic [IDX_W-1:0]    i_lk_idx,
    output logic [CTR_BITS-1:0] o_lk_ctr
);

    // Weakly not-taken: MSB clear, all lower bits set.
    localparam logic [CTR_BITS-1:0] CTR_INIT =
        CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};

    function automatic logic [CTR_BITS-1:0] sat_next(
        input logic [CTR_BITS-1:0] ctr,
        input logic                tk
    );
        if (tk)
            sat_next = (ctr == CTR_MAX) ? ctr : ctr + 1'b1;
        else
            sat_next = (ctr == '0) ? ctr : ctr - 1'b1;
    endfunction

    logic [CTR_BITS-1:0] r_pht [PHT_DEPTH];

    // Lookup reads registered state only, so a same-cycle update is not seen.
    assign o_lk_ctr = r_pht[i_lk_idx];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < PHT_DEPTH; i++)
                r_pht[i] <= CTR_INIT;
        end else if (i_upd_en) begin
            r_pht[i_upd_idx] <= sat_next(r_pht[i_upd_idx], i_upd_tk);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver with PHT prediction, redirect and wrong-path squash.
// Ports: i_valid/i_stall/i_a/i_b/i_br_ty/i_pc/i_target/i_pred_tk resolve side,
// i_f_pc/o_f_pred_tk fetch lookup, o_valid/o_br_tk/o_mispredict/o_redirect_pc results,
// o_br_cnt/o_mispred_cnt perf counters (present only with BR_PERF_CNT_EN defined).
module branch_resolve_unit
    import enum_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int PHT_DEPTH = 64,
    parameter int CTR_BITS  = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic            i_stall,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [2:0]      i_br_ty,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_target,
    input  logic            i_pred_tk,
    input  logic [XLEN-1:0] i_f_pc,
    output logic            o_f_pred_tk,
    output logic            o_valid,
    output logic            o_br_tk,
    output logic            o_mispredict,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic [31:0]     o_br_cnt,
    output logic [31:0]     o_mispred_cnt
);

    localparam int IDX_W = $clog2(PHT_DEPTH);

    br_ty_e              w_ty;
    logic                w_tk;
    logic                w_cond;
    logic                w_accept;
    logic                w_mis;
    logic [XLEN-1:0]     w_pc4;
    logic [CTR_BITS-1:0] w_lk_ctr;
    logic                w_unused_fpc;
    logic                r_squash;

    assign w_ty = br_ty_e'(i_br_ty);

    always_comb begin
        w_tk = 1'b0;
        unique case (w_ty)
            BEQ:  w_tk = (i_a == i_b);
            BNE:  w_tk = (i_a != i_b);
            BLT:  w_tk = ($signed(i_a) < $signed(i_b));
            BGE:  w_tk = ($signed(i_a) >= $signed(i_b));
            BLTU: w_tk = (i_a < i_b);
            BGEU: w_tk = (i_a >= i_b);
            NB:   w_tk = 1'b0;
            J:    w_tk = 1'b1;
            default: w_tk = 1'b0;
        endcase
    end

    assign w_cond   = (w_ty != NB) && (w_ty != J);
    assign w_accept = i_valid && !i_stall && !r_squash;
    assign w_mis    = (w_tk != i_pred_tk);
    assign w_pc4    = i_pc + XLEN'(4);

    // Only the index bits of the fetch PC take part in the lookup.
    assign w_unused_fpc =
        ^{i_f_pc[XLEN-1:IDX_W+2], i_f_pc[1:0]};

    branch_pht #(
        .PHT_DEPTH (PHT_DEPTH),
        .CTR_BITS  (CTR_BITS),
        .IDX_W     (IDX_W)
    ) u_pht (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_upd_en  (w_accept && w_cond),
        .i_upd_idx (i_pc[IDX_W+1:2]),
        .i_upd_tk  (w_tk),
        .i_lk_idx  (i_f_pc[IDX_W+1:2]),
        .o_lk_ctr  (w_lk_ctr)
    );

    assign o_f_pred_tk = w_lk_ctr[CTR_BITS-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid       <= 1'b0;
            o_br_tk       <= 1'b0;
            o_mispredict  <= 1'b0;
            o_redirect_pc <= '0;
            r_squash      <= 1'b0;
        end else if (!i_stall) begin
            if (w_accept) begin
                o_valid       <= 1'b1;
                o_br_tk       <= w_tk;
                o_mispredict  <= w_mis;
                o_redirect_pc <= w_tk ? i_target : w_pc4;
                r_squash      <= w_mis;
            end else begin
                // Either idle or dropping the wrong-path slot.
                o_valid       <= 1'b0;
                o_mispredict  <= 1'b0;
                r_squash      <= 1'b0;
            end
        end
    end

`ifdef BR_PERF_CNT_EN
    logic [31:0] r_br_cnt;
    logic [31:0] r_mispred_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_br_cnt      <= '0;
            r_mispred_cnt <= '0;
        end else if (w_accept) begin
            if (w_cond)
                r_br_cnt <= r_br_cnt + 32'd1;
            if (w_mis)
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    assign o_br_cnt      = r_br_cnt;
    assign o_mispred_cnt = r_mispred_cnt;
`else
    assign o_br_cnt      = '0;
    assign o_mispred_cnt = '0;
`endif

endmodule
